// File: rtl/armleocpu_fetch_queue.sv
// rtl/armleocpu_fetch_queue.sv - prefetching fetch unit with DEPTH-entry instruction queue

`ifndef CACHE_CMD_NONE
`define CACHE_CMD_NONE 4'd0
`endif
`ifndef CACHE_CMD_EXECUTE
`define CACHE_CMD_EXECUTE 4'd1
`endif
`ifndef CACHE_CMD_FLUSH_ALL
`define CACHE_CMD_FLUSH_ALL 4'd4
`endif
`ifndef CACHE_RESPONSE_SUCCESS
`define CACHE_RESPONSE_SUCCESS 4'd0
`endif
`ifndef DEBUG_CMD_WIDTH
`define DEBUG_CMD_WIDTH 4
`endif
`ifndef DEBUG_CMD_READ_PC
`define DEBUG_CMD_READ_PC 4'd1
`endif
`ifndef DEBUG_CMD_JUMP
`define DEBUG_CMD_JUMP 4'd2
`endif
`ifndef F2E_TYPE_WIDTH
`define F2E_TYPE_WIDTH 1
`endif
`ifndef F2E_TYPE_INSTR
`define F2E_TYPE_INSTR 1'd0
`endif
`ifndef F2E_TYPE_INTERRUPT_PENDING
`define F2E_TYPE_INTERRUPT_PENDING 1'd1
`endif
`ifndef ARMLEOCPU_D2F_CMD_WIDTH
`define ARMLEOCPU_D2F_CMD_WIDTH 2
`endif
`ifndef ARMLEOCPU_D2F_CMD_NONE
`define ARMLEOCPU_D2F_CMD_NONE 2'd0
`endif
`ifndef ARMLEOCPU_D2F_CMD_START_BRANCH
`define ARMLEOCPU_D2F_CMD_START_BRANCH 2'd1
`endif
`ifndef ARMLEOCPU_D2F_CMD_FLUSH
`define ARMLEOCPU_D2F_CMD_FLUSH 2'd2
`endif

module armleocpu_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int STOP_ON_ERROR = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [31:0]                          reset_vector,

    output logic [3:0]                           c_cmd,
    output logic [31:0]                          c_address,
    input  logic                                 c_done,
    input  logic [3:0]                           c_response,
    input  logic [31:0]                          c_load_data,

    input  logic                                 interrupt_pending,

    input  logic                                 dbg_mode,
    input  logic                                 dbg_cmd_valid,
    input  logic [`DEBUG_CMD_WIDTH-1:0]          dbg_cmd,
    input  logic [31:0]                          dbg_arg0_i,
    output logic [31:0]                          dbg_arg0_o,
    output logic                                 dbg_cmd_ready,
    output logic                                 dbg_pipeline_busy,

    output logic                                 f2d_valid,
    output logic [`F2E_TYPE_WIDTH-1:0]           f2d_type,
    output logic [31:0]                          f2d_instr,
    output logic [31:0]                          f2d_pc,
    output logic [3:0]                           f2d_resp,

    input  logic                                 d2f_ready,
    input  logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0]  d2f_cmd,
    input  logic [31:0]                          d2f_branchtarget
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [3:0]    q_resp  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [31:0]   next_pc;
    logic [3:0]    out_cmd;
    logic [31:0]   out_addr;
    logic          discard;
    logic          flush_pending;
    logic          halted_err;

    logic          outstanding;
    logic          done_now;
    logic          done_exec;
    logic          done_flush;
    logic          dbg_accept;
    logic          dbg_jump;
    logic          d2f_branch;
    logic          d2f_flush;
    logic          redirect;
    logic          clear_q;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;
    logic          halted_next;
    logic          flush_next;
    logic          discard_next;
    logic [31:0]   base_pc;
    logic          slot_free;
    logic          issue_exec;
    logic          issue_flush;

    // Control decisions for this cycle; all "next" values feed both the issue gate and the registers
    always_comb begin
        outstanding = (out_cmd != `CACHE_CMD_NONE);
        done_now    = outstanding && c_done;
        done_exec   = done_now && (out_cmd == `CACHE_CMD_EXECUTE);
        done_flush  = done_now && (out_cmd == `CACHE_CMD_FLUSH_ALL);

        // Debug commands only land while halted with nothing in flight, so a jump never needs discard
        dbg_accept  = dbg_mode && !outstanding && dbg_cmd_valid;
        dbg_jump    = dbg_accept && (dbg_cmd == `DEBUG_CMD_JUMP);

        d2f_branch  = d2f_ready && (d2f_cmd == `ARMLEOCPU_D2F_CMD_START_BRANCH) && !dbg_jump;
        d2f_flush   = d2f_ready && (d2f_cmd == `ARMLEOCPU_D2F_CMD_FLUSH) && !dbg_jump;
        redirect    = d2f_branch || d2f_flush;
        clear_q     = redirect || dbg_jump;

        push        = done_exec && !discard && !clear_q;
        pop         = (count != '0) && d2f_ready && !clear_q;
        count_next  = clear_q ? '0 : (count + CW'(push) - CW'(pop));

        halted_next = clear_q ? 1'b0
                    : (halted_err || ((STOP_ON_ERROR != 0) && push
                                      && (c_response != `CACHE_RESPONSE_SUCCESS)));
        flush_next  = d2f_flush ? 1'b1 : (done_flush ? 1'b0 : flush_pending);

        // A redirect that overtakes an in-flight fetch must swallow its eventual response
        if (redirect && outstanding && !c_done)
            discard_next = 1'b1;
        else if (done_now)
            discard_next = 1'b0;
        else
            discard_next = discard;

        base_pc     = dbg_jump ? dbg_arg0_i : (redirect ? d2f_branchtarget : next_pc);

        slot_free   = !outstanding || done_now;
        issue_flush = slot_free && flush_next && !dbg_mode;
        issue_exec  = slot_free && !flush_next && !halted_next && !dbg_mode
                      && !interrupt_pending && (count_next < DEPTH_C);
    end

    // Control state: pointers, occupancy, program counter, outstanding request and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            next_pc       <= reset_vector;
            out_cmd       <= `CACHE_CMD_NONE;
            out_addr      <= '0;
            discard       <= 1'b0;
            flush_pending <= 1'b0;
            halted_err    <= 1'b0;
        end else begin
            count         <= count_next;
            halted_err    <= halted_next;
            flush_pending <= flush_next;
            discard       <= discard_next;
            if (clear_q) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
            next_pc <= issue_exec ? (base_pc + 32'd4) : base_pc;
            if (issue_exec) begin
                out_cmd  <= `CACHE_CMD_EXECUTE;
                out_addr <= base_pc;
            end else if (issue_flush) begin
                out_cmd  <= `CACHE_CMD_FLUSH_ALL;
                out_addr <= base_pc;
            end else if (done_now) begin
                out_cmd  <= `CACHE_CMD_NONE;
            end
        end
    end

    // Queue storage needs no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_instr[wr_ptr] <= c_load_data;
            q_pc[wr_ptr]    <= out_addr;
            q_resp[wr_ptr]  <= c_response;
        end
    end

    // Outputs; the cache command is gated by rst so a reset drops a request immediately
    always_comb begin
        c_cmd             = rst ? `CACHE_CMD_NONE : out_cmd;
        c_address         = out_addr;
        dbg_pipeline_busy = !rst && outstanding;
        dbg_cmd_ready     = !rst && dbg_accept;
        dbg_arg0_o        = next_pc;
        f2d_valid         = !rst && ((count != '0) || (interrupt_pending && !outstanding));
        f2d_type          = (count != '0) ? `F2E_TYPE_INSTR : `F2E_TYPE_INTERRUPT_PENDING;
        f2d_instr         = q_instr[rd_ptr];
        f2d_pc            = q_pc[rd_ptr];
        f2d_resp          = q_resp[rd_ptr];
    end

endmodule

// File: tb/tb_armleocpu_fetch_queue.sv
// tb/tb_armleocpu_fetch_queue.sv - self-checking bench for armleocpu_fetch_queue

`ifndef CACHE_CMD_NONE
`define CACHE_CMD_NONE 4'd0
`endif
`ifndef CACHE_CMD_EXECUTE
`define CACHE_CMD_EXECUTE 4'd1
`endif
`ifndef CACHE_CMD_FLUSH_ALL
`define CACHE_CMD_FLUSH_ALL 4'd4
`endif
`ifndef DEBUG_CMD_WIDTH
`define DEBUG_CMD_WIDTH 4
`endif
`ifndef DEBUG_CMD_READ_PC
`define DEBUG_CMD_READ_PC 4'd1
`endif
`ifndef DEBUG_CMD_JUMP
`define DEBUG_CMD_JUMP 4'd2
`endif
`ifndef F2E_TYPE_WIDTH
`define F2E_TYPE_WIDTH 1
`endif
`ifndef F2E_TYPE_INSTR
`define F2E_TYPE_INSTR 1'd0
`endif
`ifndef F2E_TYPE_INTERRUPT_PENDING
`define F2E_TYPE_INTERRUPT_PENDING 1'd1
`endif
`ifndef ARMLEOCPU_D2F_CMD_WIDTH
`define ARMLEOCPU_D2F_CMD_WIDTH 2
`endif
`ifndef ARMLEOCPU_D2F_CMD_NONE
`define ARMLEOCPU_D2F_CMD_NONE 2'd0
`endif
`ifndef ARMLEOCPU_D2F_CMD_START_BRANCH
`define ARMLEOCPU_D2F_CMD_START_BRANCH 2'd1
`endif
`ifndef ARMLEOCPU_D2F_CMD_FLUSH
`define ARMLEOCPU_D2F_CMD_FLUSH 2'd2
`endif

module tb_armleocpu_fetch_queue;

    localparam int DEPTH = 4;

    logic                                clk = 1'b0;
    logic                                rst;
    logic [31:0]                         reset_vector;
    logic [3:0]                          c_cmd;
    logic [31:0]                         c_address;
    logic                                c_done;
    logic [3:0]                          c_response;
    logic [31:0]                         c_load_data;
    logic                                interrupt_pending;
    logic                                dbg_mode;
    logic                                dbg_cmd_valid;
    logic [`DEBUG_CMD_WIDTH-1:0]         dbg_cmd;
    logic [31:0]                         dbg_arg0_i;
    logic [31:0]                         dbg_arg0_o;
    logic                                dbg_cmd_ready;
    logic                                dbg_pipeline_busy;
    logic                                f2d_valid;
    logic [`F2E_TYPE_WIDTH-1:0]          f2d_type;
    logic [31:0]                         f2d_instr;
    logic [31:0]                         f2d_pc;
    logic [3:0]                          f2d_resp;
    logic                                d2f_ready;
    logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd;
    logic [31:0]                         d2f_branchtarget;

    int vectors = 0;
    int miscompares = 0;

    armleocpu_fetch_queue #(.DEPTH(DEPTH), .STOP_ON_ERROR(1)) dut (
        .clk(clk), .rst(rst), .reset_vector(reset_vector),
        .c_cmd(c_cmd), .c_address(c_address), .c_done(c_done),
        .c_response(c_response), .c_load_data(c_load_data),
        .interrupt_pending(interrupt_pending),
        .dbg_mode(dbg_mode), .dbg_cmd_valid(dbg_cmd_valid), .dbg_cmd(dbg_cmd),
        .dbg_arg0_i(dbg_arg0_i), .dbg_arg0_o(dbg_arg0_o),
        .dbg_cmd_ready(dbg_cmd_ready), .dbg_pipeline_busy(dbg_pipeline_busy),
        .f2d_valid(f2d_valid), .f2d_type(f2d_type), .f2d_instr(f2d_instr),
        .f2d_pc(f2d_pc), .f2d_resp(f2d_resp),
        .d2f_ready(d2f_ready), .d2f_cmd(d2f_cmd), .d2f_branchtarget(d2f_branchtarget)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    // Advance one clock; inputs are driven and outputs sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        c_done = 0; c_response = 0; c_load_data = 0; interrupt_pending = 0;
        dbg_mode = 0; dbg_cmd_valid = 0; dbg_cmd = 0; dbg_arg0_i = 0;
        d2f_ready = 0; d2f_cmd = `ARMLEOCPU_D2F_CMD_NONE; d2f_branchtarget = 0;
    endtask

    // Reset, release, and advance one cycle so the first fetch is visible
    task automatic do_reset();
        idle_inputs();
        reset_vector = 32'h1000;
        rst = 1;
        step(); step();
        rst = 0;
        step();
    endtask

    task automatic cache_done_step(input logic [3:0] resp);
        c_done = 1; c_response = resp; c_load_data = dat(c_address);
        step();
        c_done = 0; c_response = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_vector = 32'h1000;
        rst = 1;
        step(); step();
        vectors++; if (c_cmd !== `CACHE_CMD_NONE) begin miscompares++; $display("FAIL reset_c_cmd got %h want %h", c_cmd, `CACHE_CMD_NONE); end
        vectors++; if (f2d_valid !== 1'b0) begin miscompares++; $display("FAIL reset_f2d_valid got %b want 0", f2d_valid); end
        vectors++; if (dbg_cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_dbg_ready got %b want 0", dbg_cmd_ready); end
        vectors++; if (dbg_pipeline_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", dbg_pipeline_busy); end
        vectors++; if (dbg_arg0_o !== 32'h1000) begin miscompares++; $display("FAIL reset_next_pc got %h want %h", dbg_arg0_o, 32'h1000); end
        rst = 0;
        step();
        vectors++; if (c_cmd !== `CACHE_CMD_EXECUTE || c_address !== 32'h1000) begin miscompares++; $display("FAIL first_fetch got %h@%h want %h@%h", c_cmd, c_address, `CACHE_CMD_EXECUTE, 32'h1000); end
        // Reset mid-request: command drops at once and a late done is ignored
        rst = 1;
        #1;
        vectors++; if (c_cmd !== `CACHE_CMD_NONE) begin miscompares++; $display("FAIL reset_midreq got %h want %h", c_cmd, `CACHE_CMD_NONE); end
        step();
        rst = 0; c_done = 1; c_load_data = 32'hDEAD_BEEF;
        step();
        c_done = 0;
        vectors++; if (f2d_valid !== 1'b0) begin miscompares++; $display("FAIL late_done_ignored got %b want 0", f2d_valid); end
        vectors++; if (c_cmd !== `CACHE_CMD_EXECUTE || c_address !== 32'h1000) begin miscompares++; $display("FAIL after_reset_fetch got %h@%h want %h@%h", c_cmd, c_address, `CACHE_CMD_EXECUTE, 32'h1000); end
    endtask

    task automatic test_sequential();
        do_reset();
        d2f_ready = 1;
        vectors++; if (f2d_valid !== 1'b0) begin miscompares++; $display("FAIL seq_empty got %b want 0", f2d_valid); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (c_cmd !== `CACHE_CMD_EXECUTE || c_address !== 32'h1000 + 32'(4 * i)) begin miscompares++; $display("FAIL seq_addr%0d got %h@%h want %h", i, c_cmd, c_address, 32'h1000 + 32'(4 * i)); end
            cache_done_step(4'd0);
            vectors++; if (f2d_valid !== 1'b1 || f2d_pc !== 32'h1000 + 32'(4 * i)) begin miscompares++; $display("FAIL seq_f2d%0d got %b/%h want 1/%h", i, f2d_valid, f2d_pc, 32'h1000 + 32'(4 * i)); end
            vectors++; if (f2d_instr !== dat(32'h1000 + 32'(4 * i)) || f2d_type !== `F2E_TYPE_INSTR) begin miscompares++; $display("FAIL seq_instr%0d got %h want %h", i, f2d_instr, dat(32'h1000 + 32'(4 * i))); end
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (c_cmd !== `CACHE_CMD_EXECUTE || c_address !== 32'h1000 + 32'(4 * i)) begin miscompares++; $display("FAIL fill_addr%0d got %h@%h want %h", i, c_cmd, c_address, 32'h1000 + 32'(4 * i)); end
            cache_done_step(4'd0);
        end
        step(); step();
        vectors++; if (c_cmd !== `CACHE_CMD_NONE) begin miscompares++; $display("FAIL fill_stop got %h want %h", c_cmd, `CACHE_CMD_NONE); end
        d2f_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (f2d_valid !== 1'b1 || f2d_pc !== 32'h1000 + 32'(4 * i) || f2d_instr !== dat(32'h1000 + 32'(4 * i))) begin miscompares++; $display("FAIL drain%0d got %b/%h/%h want 1/%h", i, f2d_valid, f2d_pc, f2d_instr, 32'h1000 + 32'(4 * i)); end
            step();
            if (i == 0) begin
                vectors++; if (c_cmd !== `CACHE_CMD_EXECUTE || c_address !== 32'h1010) begin miscompares++; $display("FAIL fill_resume got %h@%h want %h@%h", c_cmd, c_address, `CACHE_CMD_EXECUTE, 32'h1010); end
            end
        end
        vectors++; if (f2d_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got %b want 0", f2d_valid); end
    endtask

    task automatic test_branch();
        do_reset();
        d2f_ready = 1;
        cache_done_step(4'd0);
        cache_done_step(4'd0);
        d2f_cmd = `ARMLEOCPU_D2F_CMD_START_BRANCH; d2f_branchtarget = 32'h2000;
        step();
        d2f_cmd = `ARMLEOCPU_D2F_CMD_NONE;
        vectors++; if (c_cmd !== `CACHE_CMD_EXECUTE || c_address !== 32'h1008) begin miscompares++; $display("FAIL br_hold got %h@%h want %h@%h", c_cmd, c_address, `CACHE_CMD_EXECUTE, 32'h1008); end
        vectors++; if (f2d_valid !== 1'b0) begin miscompares++; $display("FAIL br_cleared got %b want 0", f2d_valid); end
        step();
        vectors++; if (c_address !== 32'h1008) begin miscompares++; $display("FAIL br_hold2 got %h want %h", c_address, 32'h1008); end
        cache_done_step(4'd0);
        vectors++; if (f2d_valid !== 1'b0) begin miscompares++; $display("FAIL br_discard got %b want 0", f2d_valid); end
        vectors++; if (c_cmd !== `CACHE_CMD_EXECUTE || c_address !== 32'h2000) begin miscompares++; $display("FAIL br_target got %h@%h want %h@%h", c_cmd, c_address, `CACHE_CMD_EXECUTE, 32'h2000); end
        cache_done_step(4'd0);
        vectors++; if (f2d_valid !== 1'b1 || f2d_pc !== 32'h2000) begin miscompares++; $display("FAIL br_entry got %b/%h want 1/%h", f2d_valid, f2d_pc, 32'h2000); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cache_done_step(4'd0);
        d2f_ready = 1; d2f_cmd = `ARMLEOCPU_D2F_CMD_FLUSH; d2f_branchtarget = 32'h3000;
        step();
        d2f_cmd = `ARMLEOCPU_D2F_CMD_NONE;
        vectors++; if (c_cmd !== `CACHE_CMD_FLUSH_ALL) begin miscompares++; $display("FAIL flush_cmd got %h want %h", c_cmd, `CACHE_CMD_FLUSH_ALL); end
        vectors++; if (f2d_valid !== 1'b0) begin miscompares++; $display("FAIL flush_cleared got %b want 0", f2d_valid); end
        cache_done_step(4'd0);
        vectors++; if (c_cmd !== `CACHE_CMD_EXECUTE || c_address !== 32'h3000) begin miscompares++; $display("FAIL flush_resume got %h@%h want %h@%h", c_cmd, c_address, `CACHE_CMD_EXECUTE, 32'h3000); end
    endtask

    task automatic test_error();
        do_reset();
        cache_done_step(4'd0);
        cache_done_step(4'd1);
        vectors++; if (c_cmd !== `CACHE_CMD_NONE) begin miscompares++; $display("FAIL err_stop got %h want %h", c_cmd, `CACHE_CMD_NONE); end
        step(); step();
        vectors++; if (c_cmd !== `CACHE_CMD_NONE) begin miscompares++; $display("FAIL err_stop2 got %h want %h", c_cmd, `CACHE_CMD_NONE); end
        d2f_ready = 1;
        vectors++; if (f2d_pc !== 32'h1000 || f2d_resp !== 4'd0) begin miscompares++; $display("FAIL err_head0 got %h/%h want %h/0", f2d_pc, f2d_resp, 32'h1000); end
        step();
        vectors++; if (f2d_valid !== 1'b1 || f2d_pc !== 32'h1004 || f2d_resp !== 4'd1) begin miscompares++; $display("FAIL err_head1 got %b/%h/%h want 1/%h/1", f2d_valid, f2d_pc, f2d_resp, 32'h1004); end
        step();
        vectors++; if (f2d_valid !== 1'b0 || c_cmd !== `CACHE_CMD_NONE) begin miscompares++; $display("FAIL err_idle got %b/%h want 0/%h", f2d_valid, c_cmd, `CACHE_CMD_NONE); end
        d2f_cmd = `ARMLEOCPU_D2F_CMD_START_BRANCH; d2f_branchtarget = 32'h4000;
        step();
        d2f_cmd = `ARMLEOCPU_D2F_CMD_NONE;
        vectors++; if (c_cmd !== `CACHE_CMD_EXECUTE || c_address !== 32'h4000) begin miscompares++; $display("FAIL err_branch got %h@%h want %h@%h", c_cmd, c_address, `CACHE_CMD_EXECUTE, 32'h4000); end
    endtask

    task automatic test_debug();
        do_reset();
        d2f_ready = 1;
        dbg_mode = 1;
        step();
        vectors++; if (dbg_pipeline_busy !== 1'b1 || c_address !== 32'h1000) begin miscompares++; $display("FAIL dbg_busy got %b@%h want 1@%h", dbg_pipeline_busy, c_address, 32'h1000); end
        cache_done_step(4'd0);
        vectors++; if (dbg_pipeline_busy !== 1'b0 || c_cmd !== `CACHE_CMD_NONE) begin miscompares++; $display("FAIL dbg_idle got %b/%h want 0/%h", dbg_pipeline_busy, c_cmd, `CACHE_CMD_NONE); end
        dbg_cmd_valid = 1; dbg_cmd = `DEBUG_CMD_JUMP; dbg_arg0_i = 32'h5000;
        #1;
        vectors++; if (dbg_cmd_ready !== 1'b1) begin miscompares++; $display("FAIL dbg_jump_ready got %b want 1", dbg_cmd_ready); end
        step();
        dbg_cmd_valid = 0;
        #1;
        vectors++; if (dbg_cmd_ready !== 1'b0) begin miscompares++; $display("FAIL dbg_ready_pulse got %b want 0", dbg_cmd_ready); end
        vectors++; if (f2d_valid !== 1'b0) begin miscompares++; $display("FAIL dbg_jump_clear got %b want 0", f2d_valid); end
        dbg_cmd_valid = 1; dbg_cmd = `DEBUG_CMD_READ_PC;
        #1;
        vectors++; if (dbg_cmd_ready !== 1'b1 || dbg_arg0_o !== 32'h5000) begin miscompares++; $display("FAIL dbg_read_pc got %b/%h want 1/%h", dbg_cmd_ready, dbg_arg0_o, 32'h5000); end
        step();
        dbg_cmd_valid = 0;
        vectors++; if (c_cmd !== `CACHE_CMD_NONE) begin miscompares++; $display("FAIL dbg_halted got %h want %h", c_cmd, `CACHE_CMD_NONE); end
        dbg_mode = 0;
        step();
        vectors++; if (c_cmd !== `CACHE_CMD_EXECUTE || c_address !== 32'h5000) begin miscompares++; $display("FAIL dbg_resume got %h@%h want %h@%h", c_cmd, c_address, `CACHE_CMD_EXECUTE, 32'h5000); end
    endtask

    task automatic test_interrupt();
        idle_inputs();
        reset_vector = 32'h1000;
        rst = 1; interrupt_pending = 1;
        step();
        rst = 0;
        step();
        vectors++; if (f2d_valid !== 1'b1 || f2d_type !== `F2E_TYPE_INTERRUPT_PENDING) begin miscompares++; $display("FAIL irq_f2d got %b/%h want 1/%h", f2d_valid, f2d_type, `F2E_TYPE_INTERRUPT_PENDING); end
        vectors++; if (c_cmd !== `CACHE_CMD_NONE) begin miscompares++; $display("FAIL irq_no_issue got %h want %h", c_cmd, `CACHE_CMD_NONE); end
        interrupt_pending = 0;
        step();
        vectors++; if (c_cmd !== `CACHE_CMD_EXECUTE || c_address !== 32'h1000 || f2d_valid !== 1'b0) begin miscompares++; $display("FAIL irq_release got %h@%h/%b want %h@%h/0", c_cmd, c_address, f2d_valid, `CACHE_CMD_EXECUTE, 32'h1000); end
    endtask

    // Random ready, cache latency and branches against a queue-of-PCs model
    task automatic test_random();
        logic [31:0] model_q[$];
        logic [31:0] exp_next;
        logic [31:0] req_addr;
        logic        req_active;
        logic        req_discard;
        logic        br;
        logic        pop;
        int          lat;
        int          pops;
        do_reset();
        exp_next = 32'h1000; req_addr = 0; req_active = 0; req_discard = 0; lat = 0; pops = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (model_q.size() != 0) begin
                vectors++; if (f2d_valid !== 1'b1 || f2d_pc !== model_q[0] || f2d_instr !== dat(model_q[0])) begin miscompares++; $display("FAIL rnd_head c%0d got %b/%h/%h want 1/%h", cyc, f2d_valid, f2d_pc, f2d_instr, model_q[0]); end
            end else begin
                vectors++; if (f2d_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_empty c%0d got %b want 0", cyc, f2d_valid); end
            end
            if (req_active) begin
                vectors++; if (c_cmd !== `CACHE_CMD_EXECUTE || c_address !== req_addr) begin miscompares++; $display("FAIL rnd_hold c%0d got %h@%h want %h@%h", cyc, c_cmd, c_address, `CACHE_CMD_EXECUTE, req_addr); end
            end else if (c_cmd == `CACHE_CMD_EXECUTE) begin
                vectors++; if (c_address !== exp_next) begin miscompares++; $display("FAIL rnd_addr c%0d got %h want %h", cyc, c_address, exp_next); end
                vectors++; if (model_q.size() >= DEPTH) begin miscompares++; $display("FAIL rnd_overfetch c%0d got %0d want <%0d", cyc, model_q.size(), DEPTH); end
                req_active = 1; req_discard = 0; req_addr = exp_next;
                exp_next = exp_next + 32'd4;
                lat = int'($urandom_range(0, 3));
            end else begin
                vectors++; if (model_q.size() != DEPTH) begin miscompares++; $display("FAIL rnd_stall c%0d got %0d entries want %0d with cache idle", cyc, model_q.size(), DEPTH); end
            end
            c_done = req_active && (lat == 0);
            if (req_active && lat != 0) lat--;
            c_load_data = dat(req_addr); c_response = 0;
            d2f_ready = ($urandom_range(0, 3) != 0);
            br = ($urandom_range(0, 15) == 0);
            d2f_cmd = br ? `ARMLEOCPU_D2F_CMD_START_BRANCH : `ARMLEOCPU_D2F_CMD_NONE;
            d2f_branchtarget = $urandom() & 32'hFFFF_FFFC;
            pop = (model_q.size() != 0) && d2f_ready;
            @(posedge clk);
            if (d2f_ready && br) begin
                model_q.delete();
                exp_next = d2f_branchtarget;
                if (req_active && !c_done) req_discard = 1;
            end else begin
                if (pop) begin void'(model_q.pop_front()); pops++; end
                if (req_active && c_done && !req_discard) model_q.push_back(req_addr);
            end
            if (c_done) req_active = 0;
            @(negedge clk);
            c_done = 0;
        end
        vectors++; if (pops < 100) begin miscompares++; $display("FAIL rnd_progress got %0d pops want >=100", pops); end
        d2f_cmd = `ARMLEOCPU_D2F_CMD_NONE;
    endtask

    initial begin
        rst = 1; reset_vector = 32'h1000;
        idle_inputs();
        test_reset();
        test_sequential();
        test_fill();
        test_branch();
        test_flush();
        test_error();
        test_debug();
        test_interrupt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
